dma_timing_ctrl: RTL and testbench



---
 rtl/dma_timing_ctrl_pkg.sv | 15 +
 rtl/dma_timing_ctrl_strobe.sv | 21 ++
 rtl/dma_timing_ctrl.sv | 99 +++++++++
 tb/tb_dma_timing_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dma_timing_ctrl_pkg.sv
// dma_timing_ctrl_pkg: state and transfer encodings shared by the DMA timing controller
package DmaPackage;
  localparam logic [2:0] ST_SI = 3'd0;
  localparam logic [2:0] ST_S0 = 3'd1;
  localparam logic [2:0] ST_S1 = 3'd2;
  localparam logic [2:0] ST_S2 = 3'd3;
  localparam logic [2:0] ST_S3 = 3'd4;
  localparam logic [2:0] ST_S4 = 3'd5;
  localparam logic [2:0] ST_SC = 3'd6;
  typedef enum logic [2:0] {
    SI = ST_SI, S0 = ST_S0, S1 = ST_S1, S2 = ST_S2, S3 = ST_S3, S4 = ST_S4, SC = ST_SC
  } dma_state_t;
  typedef enum logic [1:0] {DEMAND = 2'b00, SINGLE = 2'b01, BLOCK = 2'b10, CASCADE = 2'b11} xfer_mode_t;
  typedef enum logic [1:0] {VERIFY = 2'b00, WRITE = 2'b01, READ = 2'b10, ILLEGAL = 2'b11} xfer_type_t;
endpackage

// File: rtl/dma_timing_ctrl_strobe.sv
// dma_strobe_decode: bus strobes from transfer state and direction
module dma_strobe_decode
  import DmaPackage::*;
(
  input  dma_state_t state,
  input  xfer_type_t xferType,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n
);
  logic rdPhase, wrPhase;
  always_comb begin
    rdPhase = state == S2 || state == S3;
    wrPhase = state == S3;
    memr_n  = !(rdPhase && xferType == READ);
    ior_n   = !(rdPhase && xferType == WRITE);
    iow_n   = !(wrPhase && xferType == READ);
    memw_n  = !(wrPhase && xferType == WRITE);
  end
endmodule

// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl: HRQ/HLDA handshake and SI/S0-S4/SC transfer sequencer
module dma_timing_ctrl
  import DmaPackage::*;
#(
  parameter int HLDA_TIMEOUT = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  input  logic [1:0] grant_ch,
  input  logic       HLDA,
  input  logic       EOP_n,
  input  logic [1:0] xfer_mode,
  input  logic [1:0] xfer_type,
  input  logic       autoinit,
  input  logic       count_zero,
  input  logic       adr_carry,
  output logic       hrq,
  output logic       validDACK,
  output logic [1:0] active_ch,
  output logic       aen,
  output logic       adstb,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n,
  output logic       addr_update,
  output logic       reload,
  output logic       tc_pulse,
  output logic       eop_out_n
);
  dma_state_t state, nextState;
  xfer_mode_t modeL;
  xfer_type_t typeL;
  logic       autoinitL, eopFlag, xferState, term, timeout, s4Live;
  logic [1:0] activeCh;
  logic [15:0] waitCnt;
  always_comb begin
    xferState = state == S1 || state == S2 || state == S3 || state == S4;
    term      = count_zero || eopFlag;
    timeout   = HLDA_TIMEOUT != 0 && waitCnt == 16'(HLDA_TIMEOUT - 1);
    nextState = state;
    case (state)
      SI: nextState = req_valid ? S0 : SI;
      S0: nextState = HLDA ? (modeL == CASCADE ? SC : S1) : (!req_valid || timeout) ? SI : S0;
      S1: nextState = S2;
      S2: nextState = S3;
      S3: nextState = S4;
      S4: nextState = (term || modeL == SINGLE || (modeL == DEMAND && !req_valid)) ? SI
                    : adr_carry ? S1 : S2;
      SC: nextState = (!req_valid || !EOP_n || eopFlag) ? SI : SC;
      default: nextState = SI;
    endcase
    // Losing the bus mid-transfer abandons the word outright
    if (xferState && !HLDA) nextState = SI;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= SI;
      activeCh  <= 2'd0;
      modeL     <= DEMAND;
      typeL     <= VERIFY;
      autoinitL <= 1'b0;
      eopFlag   <= 1'b0;
      waitCnt   <= 16'd0;
    end else begin
      state   <= nextState;
      eopFlag <= state == SI ? 1'b0 : eopFlag || (!EOP_n && (xferState || state == SC));
      waitCnt <= state == S0 ? waitCnt + 16'd1 : 16'd0;
      if (state == SI && req_valid) begin
        activeCh  <= grant_ch;
        modeL     <= xfer_mode_t'(xfer_mode);
        typeL     <= xfer_type_t'(xfer_type);
        autoinitL <= autoinit;
      end
    end
  end
  dma_strobe_decode u_strobe (
    .state   (state),
    .xferType(typeL),
    .memr_n  (memr_n),
    .memw_n  (memw_n),
    .ior_n   (ior_n),
    .iow_n   (iow_n)
  );
  // S4 pulses are suppressed if HLDA has already gone away
  always_comb begin
    s4Live      = state == S4 && HLDA;
    hrq         = state != SI;
    validDACK   = state == S2 || state == S3 || state == S4 || state == SC;
    aen         = xferState;
    adstb       = state == S1;
    addr_update = s4Live;
    tc_pulse    = s4Live && count_zero;
    eop_out_n   = !(s4Live && term);
    reload      = s4Live && term && autoinitL;
    active_ch   = activeCh;
  end
endmodule

// File: tb/tb_dma_timing_ctrl.sv
// tb_dma_timing_ctrl: directed-vector bench for dma_timing_ctrl
module tb_dma_timing_ctrl;
  logic       CLK = 1'b0, RESET = 1'b1;
  logic       req_valid = 0, HLDA = 0, EOP_n = 1, autoinit = 0, count_zero = 0, adr_carry = 0;
  logic [1:0] grant_ch = 0, xfer_mode = 0, xfer_type = 0;
  logic       hrq, validDACK, aen, adstb, memr_n, memw_n, ior_n, iow_n;
  logic       addr_update, reload, tc_pulse, eop_out_n;
  logic [1:0] active_ch;
  logic [11:0] outs;
  int nChecks = 0, nFails = 0;
  // {hrq,validDACK,aen,adstb, memr_n,memw_n,ior_n,iow_n, addr_update,reload,tc_pulse,eop_out_n}
  localparam logic [11:0] IDLE  = 12'b0000_1111_0001;
  localparam logic [11:0] WAIT  = 12'b1000_1111_0001;
  localparam logic [11:0] ADR   = 12'b1011_1111_0001;
  localparam logic [11:0] RD_S2 = 12'b1110_0111_0001;
  localparam logic [11:0] RD_S3 = 12'b1110_0110_0001;
  localparam logic [11:0] WR_S2 = 12'b1110_1101_0001;
  localparam logic [11:0] WR_S3 = 12'b1110_1001_0001;
  localparam logic [11:0] S4_GO = 12'b1110_1111_1001;
  localparam logic [11:0] S4_TC = 12'b1110_1111_1010;
  localparam logic [11:0] S4_TA = 12'b1110_1111_1110;
  localparam logic [11:0] S4_EP = 12'b1110_1111_1000;
  localparam logic [11:0] CASC  = 12'b1100_1111_0001;

  dma_timing_ctrl #(.HLDA_TIMEOUT(3)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .grant_ch(grant_ch), .HLDA(HLDA),
    .EOP_n(EOP_n), .xfer_mode(xfer_mode), .xfer_type(xfer_type), .autoinit(autoinit),
    .count_zero(count_zero), .adr_carry(adr_carry), .hrq(hrq), .validDACK(validDACK),
    .active_ch(active_ch), .aen(aen), .adstb(adstb), .memr_n(memr_n), .memw_n(memw_n),
    .ior_n(ior_n), .iow_n(iow_n), .addr_update(addr_update), .reload(reload),
    .tc_pulse(tc_pulse), .eop_out_n(eop_out_n)
  );
  assign outs = {hrq, validDACK, aen, adstb, memr_n, memw_n, ior_n, iow_n,
                 addr_update, reload, tc_pulse, eop_out_n};
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    step(); step();
    check("reset outs", 32'(outs), 32'(IDLE));
    check("reset ch", 32'(active_ch), 0);
    RESET = 0;
    // single read on channel 2, HLDA two cycles after hrq
    req_valid = 1; grant_ch = 2; xfer_mode = 2'b01; xfer_type = 2'b10;
    step(); check("sr s0a", 32'(outs), 32'(WAIT));
    grant_ch = 1;
    step(); check("sr s0b", 32'(outs), 32'(WAIT));
    HLDA = 1;
    step(); check("sr s1", 32'(outs), 32'(ADR));
    step(); check("sr s2", 32'(outs), 32'(RD_S2));
    step(); check("sr s3", 32'(outs), 32'(RD_S3));
    step(); check("sr s4", 32'(outs), 32'(S4_GO));
    check("sr ch", 32'(active_ch), 2);
    step(); check("sr si", 32'(outs), 32'(IDLE));
    // block write, three words, carry after word 1, TC on word 3
    grant_ch = 1; xfer_mode = 2'b10; xfer_type = 2'b01;
    step(); check("bw s0", 32'(outs), 32'(WAIT));
    step(); check("bw w1 s1", 32'(outs), 32'(ADR));
    step(); check("bw w1 s2", 32'(outs), 32'(WR_S2));
    step(); check("bw w1 s3", 32'(outs), 32'(WR_S3));
    step(); check("bw w1 s4", 32'(outs), 32'(S4_GO));
    adr_carry = 1;
    step(); check("bw w2 s1", 32'(outs), 32'(ADR));
    adr_carry = 0;
    step(); check("bw w2 s2", 32'(outs), 32'(WR_S2));
    step(); check("bw w2 s3", 32'(outs), 32'(WR_S3));
    step(); check("bw w2 s4", 32'(outs), 32'(S4_GO));
    step(); check("bw w3 s2", 32'(outs), 32'(WR_S2));
    step(); check("bw w3 s3", 32'(outs), 32'(WR_S3));
    step(); count_zero = 1; #1 check("bw w3 tc", 32'(outs), 32'(S4_TC));
    check("bw ch", 32'(active_ch), 1);
    step(); check("bw si", 32'(outs), 32'(IDLE));
    count_zero = 0;
    // demand read with autoinit, request drops after one word
    grant_ch = 3; xfer_mode = 2'b00; xfer_type = 2'b10; autoinit = 1;
    step(); check("dm s0", 32'(outs), 32'(WAIT));
    step(); step(); step();
    check("dm s3", 32'(outs), 32'(RD_S3));
    step(); check("dm s4", 32'(outs), 32'(S4_GO));
    req_valid = 0;
    step(); check("dm si", 32'(outs), 32'(IDLE));
    req_valid = 1;
    step(); check("dm2 s0", 32'(outs), 32'(WAIT));
    step(); step(); step(); step();
    count_zero = 1; #1 check("dm2 tc", 32'(outs), 32'(S4_TA));
    step(); check("dm2 si", 32'(outs), 32'(IDLE));
    count_zero = 0; autoinit = 0;
    // block read terminated by external EOP during S2
    grant_ch = 0; xfer_mode = 2'b10; xfer_type = 2'b10;
    step(); step();
    step(); check("ep s2", 32'(outs), 32'(RD_S2));
    EOP_n = 0;
    step(); check("ep s3", 32'(outs), 32'(RD_S3));
    EOP_n = 1;
    step(); check("ep s4", 32'(outs), 32'(S4_EP));
    step(); check("ep si", 32'(outs), 32'(IDLE));
    // cascade on channel 0
    xfer_mode = 2'b11;
    step(); check("cs s0", 32'(outs), 32'(WAIT));
    step(); check("cs sc1", 32'(outs), 32'(CASC));
    step(); check("cs sc2", 32'(outs), 32'(CASC));
    req_valid = 0;
    step(); check("cs si", 32'(outs), 32'(IDLE));
    req_valid = 1;
    step(); step(); check("cs2 sc", 32'(outs), 32'(CASC));
    EOP_n = 0;
    step(); check("cs2 eop si", 32'(outs), 32'(IDLE));
    EOP_n = 1; req_valid = 0;
    step();
    // HLDA drop in S2 aborts without an update pulse
    req_valid = 1; grant_ch = 3; xfer_mode = 2'b01; xfer_type = 2'b01;
    step(); step();
    step(); check("ab s2", 32'(outs), 32'(WR_S2));
    HLDA = 0;
    step(); check("ab si", 32'(outs), 32'(IDLE));
    // reset asserted in S3
    HLDA = 1;
    step(); step(); step();
    step(); check("rs s3", 32'(outs), 32'(WR_S3));
    check("rs ch pre", 32'(active_ch), 3);
    RESET = 1;
    step(); check("rs outs", 32'(outs), 32'(IDLE));
    check("rs ch", 32'(active_ch), 0);
    // HLDA timeout abandons S0 after three cycles
    RESET = 0; HLDA = 0;
    step(); check("to s0a", 32'(outs), 32'(WAIT));
    step(); check("to s0b", 32'(outs), 32'(WAIT));
    step(); check("to s0c", 32'(outs), 32'(WAIT));
    step(); check("to si", 32'(outs), 32'(IDLE));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end
endmodule
